// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The optional round-robin grant policy is selected by the ARB_ROUND_ROBIN_EN macro.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // Legal wait-cycle range; the counter is sized for the upper bound.
    localparam int unsigned WAIT_MIN = 32'd1;
    localparam int unsigned WAIT_MAX = 32'd15;
    localparam int          CNT_W    = 32'd4;

    function automatic bit wait_cycles_ok(input int unsigned wait_cycles);
        return (wait_cycles >= WAIT_MIN) && (wait_cycles <= WAIT_MAX);
    endfunction

    // Counter load value; out-of-range settings are clamped into the legal range.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned wait_cycles);
        logic [CNT_W-1:0] load_v;
        if (wait_cycles_ok(wait_cycles)) begin
            load_v = CNT_W'(wait_cycles - 32'd1);
        end else if (wait_cycles < WAIT_MIN) begin
            load_v = {CNT_W{1'b0}};
        end else begin
            load_v = CNT_W'(WAIT_MAX - 32'd1);
        end
        return load_v;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the memory macro.
// slave: the arbiter's view; master: the requesters and memory model.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection between CPU and DMA requests.
// ARB_ROUND_ROBIN_EN undefined: CPU has fixed priority.
// ARB_ROUND_ROBIN_EN defined: on conflict, the port not served last wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dma_req,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

    // Choose which requester gets the next access
    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_owner = OWN_CPU;
`ifdef ARB_ROUND_ROBIN_EN
        if (cpu_req && dma_req) begin
            grant_owner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (dma_req) begin
            grant_owner = OWN_DMA;
        end else begin
            grant_owner = OWN_CPU;
        end
`else
        if (cpu_req) begin
            grant_owner = OWN_CPU;
        end else if (dma_req) begin
            grant_owner = OWN_DMA;
        end else begin
            grant_owner = OWN_CPU;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the service history.
    logic last_owner_unused_s;
    assign last_owner_unused_s = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU control unit and a DMA/loader port.
// Each grant runs WAIT_CYCLES access cycles followed by a one-cycle response.
// Grant policy: fixed CPU priority, or round-robin when ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter int unsigned WAIT_CYCLES = 32'd2
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = cnt_load(WAIT_CYCLES);

    state_e           state_r, state_nxt_s;
    owner_e           owner_r, owner_nxt_s;
    owner_e           last_owner_r, last_owner_nxt_s;
    owner_e           grant_owner_s;
    logic             grant_valid_s;
    logic             cpu_req_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [AW-1:0]    addr_r, addr_nxt_s;
    logic [DW-1:0]    wdata_r, wdata_nxt_s;
    logic             we_r, we_nxt_s;
    logic [DW-1:0]    cpu_rdata_r, cpu_rdata_nxt_s;
    logic [DW-1:0]    dma_rdata_r, dma_rdata_nxt_s;
    logic             mem_en_r, mem_en_nxt_s;
    logic             mem_we_r, mem_we_nxt_s;
    logic             dma_ack_r, dma_ack_nxt_s;

    assign cpu_req_s = bus.cpu_rd | bus.cpu_wr;

    mem_arb_pick u_pick (
        .cpu_req     (cpu_req_s),
        .dma_req     (bus.dma_req),
        .last_owner  (last_owner_r),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

    // Next state, access latches and response registers
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        last_owner_nxt_s = last_owner_r;
        cnt_nxt_s        = cnt_r;
        addr_nxt_s       = addr_r;
        wdata_nxt_s      = wdata_r;
        we_nxt_s         = we_r;
        cpu_rdata_nxt_s  = cpu_rdata_r;
        dma_rdata_nxt_s  = dma_rdata_r;
        mem_en_nxt_s     = 1'b0;
        mem_we_nxt_s     = 1'b0;
        dma_ack_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    owner_nxt_s      = grant_owner_s;
                    last_owner_nxt_s = grant_owner_s;
                    if (grant_owner_s == OWN_DMA) begin
                        addr_nxt_s  = bus.dma_addr;
                        wdata_nxt_s = bus.dma_wdata;
                        we_nxt_s    = bus.dma_we;
                    end else begin
                        addr_nxt_s  = bus.cpu_addr;
                        wdata_nxt_s = bus.cpu_wdata;
                        we_nxt_s    = bus.cpu_wr;
                    end
                    cnt_nxt_s    = CNT_LOAD;
                    state_nxt_s  = ACCESS;
                    mem_en_nxt_s = 1'b1;
                    mem_we_nxt_s = we_nxt_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    // Last wait cycle: read data is valid now.
                    if (!we_r && (owner_r == OWN_CPU)) begin
                        cpu_rdata_nxt_s = bus.mem_rdata;
                    end else if (!we_r) begin
                        dma_rdata_nxt_s = bus.mem_rdata;
                    end else begin
                        cpu_rdata_nxt_s = cpu_rdata_r;
                    end
                    dma_ack_nxt_s = (owner_r == OWN_DMA);
                    state_nxt_s   = RESP;
                end else begin
                    cnt_nxt_s    = cnt_r - 4'd1;
                    mem_en_nxt_s = 1'b1;
                    mem_we_nxt_s = we_r;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sequencer state, owner and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= OWN_CPU;
            last_owner_r <= OWN_DMA;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_owner_r <= last_owner_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    // Access latches, read-data registers and registered memory controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r      <= {AW{1'b0}};
            wdata_r     <= {DW{1'b0}};
            we_r        <= 1'b0;
            cpu_rdata_r <= {DW{1'b0}};
            dma_rdata_r <= {DW{1'b0}};
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            dma_ack_r   <= 1'b0;
        end else begin
            addr_r      <= addr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            we_r        <= we_nxt_s;
            cpu_rdata_r <= cpu_rdata_nxt_s;
            dma_rdata_r <= dma_rdata_nxt_s;
            mem_en_r    <= mem_en_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            dma_ack_r   <= dma_ack_nxt_s;
        end
    end

    // Stall releases only in the CPU's own response cycle.
    assign bus.cpu_stall = cpu_req_s & ~((state_r == RESP) & (owner_r == OWN_CPU));
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.dma_rdata = dma_rdata_r;
    assign bus.dma_ack   = dma_ack_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for WAIT_CYCLES=2 plus hand
// sequences for arbitration conflicts, reset mid-access and WAIT_CYCLES=1.
// Grant-order expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) bus2 ();

    mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(32'd2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(32'd1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    typedef struct {
        logic        crd, cwr;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe;
        logic [31:0] daddr, dwd, mrd;
        logic        x_stall, x_en, x_we;
        logic [31:0] x_addr, x_wd, x_crd, x_drd;
        logic        x_ack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic crd, input logic cwr, input logic [31:0] caddr, input logic [31:0] cwd,
        input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
        input logic [31:0] mrd,
        input logic s, input logic en, input logic we, input logic [31:0] maddr,
        input logic [31:0] mwd, input logic [31:0] xcrd, input logic [31:0] xdrd, input logic ack);
        vec_t r;
        r.crd = crd; r.cwr = cwr; r.caddr = caddr; r.cwd = cwd;
        r.dreq = dreq; r.dwe = dwe; r.daddr = daddr; r.dwd = dwd; r.mrd = mrd;
        r.x_stall = s; r.x_en = en; r.x_we = we; r.x_addr = maddr; r.x_wd = mwd;
        r.x_crd = xcrd; r.x_drd = xdrd; r.x_ack = ack;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive1(input vec_t r);
        bus1.cpu_rd = r.crd; bus1.cpu_wr = r.cwr; bus1.cpu_addr = r.caddr; bus1.cpu_wdata = r.cwd;
        bus1.dma_req = r.dreq; bus1.dma_we = r.dwe; bus1.dma_addr = r.daddr; bus1.dma_wdata = r.dwd;
        bus1.mem_rdata = r.mrd;
    endtask

    // Waits for the next response cycle; dma=1 if the DMA port was served.
    task automatic get_grant(output logic dma, output logic ok);
        dma = 1'b0;
        ok  = 1'b0;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk); #2;
            if (bus1.dma_ack) begin
                dma = 1'b1; ok = 1'b1;
            end else if (bus1.cpu_rd && !bus1.cpu_stall) begin
                dma = 1'b0; ok = 1'b1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        dma_s, ok_s, done_s;
        logic [3:0]  exp_seq;
        int          win, en_cnt;
        vec_t        z;

        z = v(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0,0,0);
        drive1(z);
        bus2.cpu_rd = 1'b0; bus2.cpu_wr = 1'b0; bus2.cpu_addr = 32'h0; bus2.cpu_wdata = 32'h0;
        bus2.dma_req = 1'b0; bus2.dma_we = 1'b0; bus2.dma_addr = 32'h0; bus2.dma_wdata = 32'h0;
        bus2.mem_rdata = 32'h0;

        // ---- reset state ----
        #12;
        check("rst mem_en", bus1.mem_en, 0);
        check("rst mem_we", bus1.mem_we, 0);
        check("rst mem_addr", bus1.mem_addr, 0);
        check("rst mem_wdata", bus1.mem_wdata, 0);
        check("rst cpu_rdata", bus1.cpu_rdata, 0);
        check("rst dma_rdata", bus1.dma_rdata, 0);
        check("rst dma_ack", bus1.dma_ack, 0);
        check("rst stall idle", bus1.cpu_stall, 0);
        bus1.cpu_rd = 1'b1; #1;
        check("rst stall req", bus1.cpu_stall, 1);
        bus1.cpu_rd = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // ---- repeated conflicts: grant order depends on policy ----
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b1000;
`endif
        @(negedge clk);
        bus1.cpu_rd = 1'b1; bus1.cpu_addr = 32'h60;
        bus1.dma_req = 1'b1; bus1.dma_we = 1'b0; bus1.dma_addr = 32'h70;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus1.cpu_rd = 1'b0;
            get_grant(dma_s, ok_s);
            check($sformatf("conflict%0d served", k), ok_s, 1);
            check($sformatf("conflict%0d owner", k), dma_s, exp_seq[k]);
        end
        bus1.dma_req = 1'b0;

        // ---- fresh reset, then cycle table ----
        @(negedge clk); rst_n = 1'b0; drive1(z);
        @(negedge clk); rst_n = 1'b1;

        // CPU read 0x40, data valid only in last wait cycle
        tbl.push_back(v(1,0,32'h40,0, 0,0,0,0, 32'h0,        1,0,0,32'h0,0,0,0,0));
        tbl.push_back(v(1,0,32'h40,0, 0,0,0,0, 32'h11111111, 1,1,0,32'h40,0,0,0,0));
        tbl.push_back(v(1,0,32'h40,0, 0,0,0,0, 32'h8C010004, 1,1,0,32'h40,0,0,0,0));
        tbl.push_back(v(1,0,32'h40,0, 0,0,0,0, 32'h22222222, 0,0,0,32'h40,0,32'h8C010004,0,0));
        tbl.push_back(v(0,0,0,0,      0,0,0,0, 32'h0,        0,0,0,32'h40,0,32'h8C010004,0,0));
        // DMA write 0x10 <- 0xDEADBEEF
        tbl.push_back(v(0,0,0,0, 1,1,32'h10,32'hDEADBEEF, 32'h0,        0,0,0,32'h40,0,32'h8C010004,0,0));
        tbl.push_back(v(0,0,0,0, 1,1,32'h10,32'hDEADBEEF, 32'h33333333, 0,1,1,32'h10,32'hDEADBEEF,32'h8C010004,0,0));
        tbl.push_back(v(0,0,0,0, 1,1,32'h10,32'hDEADBEEF, 32'h33333333, 0,1,1,32'h10,32'hDEADBEEF,32'h8C010004,0,0));
        tbl.push_back(v(0,0,0,0, 1,1,32'h10,32'hDEADBEEF, 32'h33333333, 0,0,0,32'h10,32'hDEADBEEF,32'h8C010004,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0,                 32'h0,        0,0,0,32'h10,32'hDEADBEEF,32'h8C010004,0,0));
        // DMA read 0x20 -> 0x0BADF00D
        tbl.push_back(v(0,0,0,0, 1,0,32'h20,0, 32'h0,        0,0,0,32'h10,32'hDEADBEEF,32'h8C010004,0,0));
        tbl.push_back(v(0,0,0,0, 1,0,32'h20,0, 32'h44444444, 0,1,0,32'h20,0,32'h8C010004,0,0));
        tbl.push_back(v(0,0,0,0, 1,0,32'h20,0, 32'h0BADF00D, 0,1,0,32'h20,0,32'h8C010004,0,0));
        tbl.push_back(v(0,0,0,0, 1,0,32'h20,0, 32'h0,        0,0,0,32'h20,0,32'h8C010004,32'h0BADF00D,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0,      32'h0,        0,0,0,32'h20,0,32'h8C010004,32'h0BADF00D,0));
        // CPU read 0x48 dropped mid-access; DMA write arrives during ACCESS and waits
        tbl.push_back(v(1,0,32'h48,0, 0,0,0,0,                    32'h0,        1,0,0,32'h20,0,32'h8C010004,32'h0BADF00D,0));
        tbl.push_back(v(0,0,0,0,      1,1,32'h30,32'h600DCAFE,    32'h0,        0,1,0,32'h48,0,32'h8C010004,32'h0BADF00D,0));
        tbl.push_back(v(0,0,0,0,      1,1,32'h30,32'h600DCAFE,    32'h13579BDF, 0,1,0,32'h48,0,32'h8C010004,32'h0BADF00D,0));
        tbl.push_back(v(0,0,0,0,      1,1,32'h30,32'h600DCAFE,    32'h0,        0,0,0,32'h48,0,32'h13579BDF,32'h0BADF00D,0));
        tbl.push_back(v(0,0,0,0,      1,1,32'h30,32'h600DCAFE,    32'h0,        0,0,0,32'h48,0,32'h13579BDF,32'h0BADF00D,0));
        tbl.push_back(v(0,0,0,0,      1,1,32'h30,32'h600DCAFE,    32'h0,        0,1,1,32'h30,32'h600DCAFE,32'h13579BDF,32'h0BADF00D,0));
        tbl.push_back(v(0,0,0,0,      1,1,32'h30,32'h600DCAFE,    32'h0,        0,1,1,32'h30,32'h600DCAFE,32'h13579BDF,32'h0BADF00D,0));
        tbl.push_back(v(0,0,0,0,      1,1,32'h30,32'h600DCAFE,    32'h0,        0,0,0,32'h30,32'h600DCAFE,32'h13579BDF,32'h0BADF00D,1));
        tbl.push_back(v(0,0,0,0,      0,0,0,0,                    32'h0,        0,0,0,32'h30,32'h600DCAFE,32'h13579BDF,32'h0BADF00D,0));
        // CPU rd+wr together: write wins, cpu_rdata untouched
        tbl.push_back(v(1,1,32'h50,32'hCAFEF00D, 0,0,0,0, 32'h0,        1,0,0,32'h30,32'h600DCAFE,32'h13579BDF,32'h0BADF00D,0));
        tbl.push_back(v(1,1,32'h50,32'hCAFEF00D, 0,0,0,0, 32'h55555555, 1,1,1,32'h50,32'hCAFEF00D,32'h13579BDF,32'h0BADF00D,0));
        tbl.push_back(v(1,1,32'h50,32'hCAFEF00D, 0,0,0,0, 32'h66666666, 1,1,1,32'h50,32'hCAFEF00D,32'h13579BDF,32'h0BADF00D,0));
        tbl.push_back(v(1,1,32'h50,32'hCAFEF00D, 0,0,0,0, 32'h0,        0,0,0,32'h50,32'hCAFEF00D,32'h13579BDF,32'h0BADF00D,0));
        tbl.push_back(v(0,0,0,0,                 0,0,0,0, 32'h0,        0,0,0,32'h50,32'hCAFEF00D,32'h13579BDF,32'h0BADF00D,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive1(tbl[i]);
            #2;
            check($sformatf("row%0d cpu_stall", i), bus1.cpu_stall, tbl[i].x_stall);
            check($sformatf("row%0d mem_en", i),    bus1.mem_en,    tbl[i].x_en);
            check($sformatf("row%0d mem_we", i),    bus1.mem_we,    tbl[i].x_we);
            check($sformatf("row%0d mem_addr", i),  bus1.mem_addr,  tbl[i].x_addr);
            check($sformatf("row%0d mem_wdata", i), bus1.mem_wdata, tbl[i].x_wd);
            check($sformatf("row%0d cpu_rdata", i), bus1.cpu_rdata, tbl[i].x_crd);
            check($sformatf("row%0d dma_rdata", i), bus1.dma_rdata, tbl[i].x_drd);
            check($sformatf("row%0d dma_ack", i),   bus1.dma_ack,   tbl[i].x_ack);
        end

        // ---- reset asserted mid-ACCESS ----
        @(negedge clk);
        bus1.cpu_rd = 1'b1; bus1.cpu_addr = 32'h80; bus1.mem_rdata = 32'h0F0F0F0F; #2;
        check("mr idle stall", bus1.cpu_stall, 1);
        @(negedge clk); #2;
        check("mr access en", bus1.mem_en, 1);
        #1 rst_n = 1'b0; #1;
        check("mr rst en", bus1.mem_en, 0);
        check("mr rst addr", bus1.mem_addr, 0);
        check("mr rst crd", bus1.cpu_rdata, 0);
        check("mr rst ack", bus1.dma_ack, 0);
        check("mr rst stall", bus1.cpu_stall, 1);
        @(negedge clk); #2;
        check("mr held en", bus1.mem_en, 0);
        check("mr held ack", bus1.dma_ack, 0);
        @(negedge clk); rst_n = 1'b1; #2;
        check("mr rel stall", bus1.cpu_stall, 1);
        check("mr rel en", bus1.mem_en, 0);
        @(negedge clk); #2;
        check("mr regrant en1", bus1.mem_en, 1);
        check("mr regrant addr", bus1.mem_addr, 32'h80);
        @(negedge clk); #2;
        check("mr regrant en2", bus1.mem_en, 1);
        @(negedge clk); #2;
        check("mr resp stall", bus1.cpu_stall, 0);
        check("mr resp en", bus1.mem_en, 0);
        check("mr resp crd", bus1.cpu_rdata, 32'h0F0F0F0F);
        check("mr resp ack", bus1.dma_ack, 0);
        bus1.cpu_rd = 1'b0;

        // ---- WAIT_CYCLES=1, CPU requesting every other cycle ----
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus2.cpu_rd = 1'b1; bus2.cpu_addr = 32'h100 + 32'(k * 4);
            bus2.mem_rdata = 32'hA0000000 + 32'(k);
            #2;
            win = 0; en_cnt = 0; done_s = 1'b0;
            for (int c = 0; c < 10 && !done_s; c++) begin
                win++;
                if (bus2.mem_en) en_cnt++;
                if (!bus2.cpu_stall) begin
                    done_s = 1'b1;
                end else begin
                    @(negedge clk); #2;
                end
            end
            check($sformatf("w1 acc%0d done", k), done_s, 1);
            check($sformatf("w1 acc%0d window", k), win, 3);
            check($sformatf("w1 acc%0d en cycles", k), en_cnt, 1);
            check($sformatf("w1 acc%0d rdata", k), bus2.cpu_rdata, 32'hA0000000 + 32'(k));
            bus2.cpu_rd = 1'b0;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single shared memory port of the multi-cycle CPU between two requesters: the microprogrammed control unit's memory accesses (MemRd/MemWr, address already selected by IorD) and a DMA/program-loader port. It runs each granted access for a fixed number of memory wait cycles. It stalls the CPU control unit until its access completes, and acknowledges DMA transfers with a one-cycle pulse. It sits between the datapath's memory-address/data muxes and the memory macro.

## Interface
- AW, 32, address width
- DW, 32, data width
- WAIT_CYCLES, 2, memory cycles per access (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_rd  in  1  CPU read request (MemRd)
- cpu_wr  in  1  CPU write request (MemWr); wins if both high
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, registered
- cpu_stall  out  1  freezes the control store address register while high
- dma_req  in  1  DMA request; held until dma_ack
- dma_we  in  1  DMA write enable
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_rdata  out  DW  DMA read data, registered
- dma_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in last wait cycle

## Operation
- FSM states: IDLE, ACCESS, RESP; owner register (CPU/DMA).
- IDLE: if any request, pick owner; latch addr, wdata, we; load cnt = WAIT_CYCLES-1; go to ACCESS.
- ACCESS: mem_en=1; mem_we/addr/wdata from latches, stable for the whole access; cnt decrements.
  - At cnt==0: capture mem_rdata into owner's rdata register on reads; writes leave it unchanged. Go to RESP.
- RESP (exactly one cycle):
  - owner CPU: cpu_stall=0.
  - owner DMA: dma_ack=1.
  - Then go to IDLE.
- cpu_stall = (cpu_rd|cpu_wr) & !(state==RESP & owner==CPU); combinational.
- A request dropped mid-access does not abort the access; the response is still issued.
- Other-port requests arriving during ACCESS/RESP wait for IDLE.
- rdata registers hold their value until that owner's next read completes.

## Timing
- Request visible in IDLE cycle t: ACCESS occupies t+1..t+WAIT_CYCLES; RESP at t+WAIT_CYCLES+1.
- CPU access costs WAIT_CYCLES+2 cycles, including arbitration.
- WAIT_CYCLES=1: single ACCESS cycle.
- Back-to-back: earliest next grant is the IDLE cycle after RESP.
- Reset (async, any state): state=IDLE, owner=CPU, cnt=0, latches=0.
  - mem_en=mem_we=0; mem_addr=mem_wdata=0; cpu_rdata=dma_rdata=0; dma_ack=0.
  - cpu_stall follows the request equation (IDLE).
  - An in-flight access is aborted with no ack.

## Configuration
- ARB_ROUND_ROBIN_EN undefined: fixed priority, CPU over DMA; DMA is served only when the CPU is not requesting in IDLE.
- ARB_ROUND_ROBIN_EN defined: when both request in IDLE, grant goes to the port not served last.
  - last_owner register resets to DMA, so the CPU wins the first conflict.
  - A single requester is always granted.

## Structure
- Package mem_arb_pkg: state enum (IDLE/ACCESS/RESP), owner encoding (OWN_CPU=0, OWN_DMA=1), WAIT_CYCLES range check constant.
- Sub-module mem_arb_pick: combinational grant selection from cpu_req, dma_req, last_owner; contains the ARB_ROUND_ROBIN_EN ifdef.

## Test plan
- CPU read, WAIT_CYCLES=2, addr 0x40, mem returns 0x8C010004:
  - cpu_stall high for 3 cycles.
  - mem_en high for exactly 2 cycles.
  - cpu_rdata=0x8C010004 in RESP; stall low in RESP.
- DMA write 0x10→0xDEADBEEF:
  - mem_we high 2 cycles with stable addr/data.
  - Single dma_ack pulse 3 cycles after the request.
  - dma_rdata unchanged.
- Simultaneous CPU read and DMA request:
  - Fixed priority: CPU served first, DMA served after CPU RESP.
  - With ARB_ROUND_ROBIN_EN: CPU, then DMA, then CPU on repeated conflicts.
- WAIT_CYCLES=1, CPU requests every other cycle: each access has a 1-cycle ACCESS and a 3-cycle total stall window.
- rst_n asserted mid-ACCESS:
  - mem_en drops immediately; no ack; state IDLE.
  - After release, a pending CPU request is re-granted from scratch.
